output_argmax_receiver: RTL



---
 rtl/output_argmax_receiver.sv | 136 +++++++++++++
 1 files changed

// File: rtl/output_argmax_receiver.sv
`default_nettype none
// ============================================================================
// Module   : output_argmax_receiver
// Brief    : Captures a packed vector of NO signed scores, scans it one element
//            per cycle and emits the index of the largest score on a
//            valid/ready stream. Define OUTPUT_ARGMAX_SCORE_EN to also emit
//            the winning score on oData_BM_Score.
// Revision : 1.0 - initial release
// ============================================================================
module output_argmax_receiver #(
    parameter int  NO    = 2,
    parameter int  NH    = 3,
    parameter int  WF    = 8,
    parameter      BURST = "yes",
    localparam int WO    = $clog2(NH) + 1 + WF,
    localparam int WC    = (NO > 1) ? $clog2(NO) : 1
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iValid_AM_Output,
    output logic             oReady_AM_Output,
    input  logic [NO*WO-1:0] iData_AM_Output,
    output logic             oValid_BM_Class,
    input  logic             iReady_BM_Class,
    output logic [WC-1:0]    oData_BM_Class
`ifdef OUTPUT_ARGMAX_SCORE_EN
    ,
    output logic [WO-1:0]    oData_BM_Score
`endif
);

    localparam bit          c_burst_en = (BURST == "yes");
    localparam logic [WC-1:0] c_last_idx = WC'(NO - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                 r_state;
    logic [NO*WO-1:0]       r_vec;
    logic signed [WO-1:0]   r_best;
    logic [WC-1:0]          r_idx;
    logic [WC-1:0]          r_cnt;
    logic                   r_valid;
    logic [WC-1:0]          r_class;

    logic                   w_ready;
    logic                   w_cap;
    logic [WO-1:0]          w_elem;
    logic [WO-1:0]          w_in_elem0;
    logic                   w_gt;
    logic                   w_last;

    assign w_ready    = !iRST && ((r_state == IDLE) ||
                        (c_burst_en && (r_state == EMIT) && iReady_BM_Class));
    assign w_cap      = iValid_AM_Output && w_ready;
    assign w_in_elem0 = iData_AM_Output[WO-1:0];
    assign w_elem     = r_vec[r_cnt*WO +: WO];
    // Strict greater-than so that ties keep the lower index.
    assign w_gt       = $signed(w_elem) > r_best;
    assign w_last     = (r_cnt == c_last_idx);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_best  <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_class <= '0;
        end else if (w_cap) begin
            r_vec  <= iData_AM_Output;
            r_best <= w_in_elem0;
            r_idx  <= '0;
            r_cnt  <= WC'(1);
            if (NO == 1) begin
                r_state <= EMIT;
                r_valid <= 1'b1;
                r_class <= '0;
            end else begin
                r_state <= SCAN;
                r_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                SCAN: begin
                    if (w_gt) begin
                        r_best <= w_elem;
                        r_idx  <= r_cnt;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    // The last compare feeds the result register directly.
                    if (w_last) begin
                        r_state <= EMIT;
                        r_valid <= 1'b1;
                        r_class <= w_gt ? r_cnt : r_idx;
                    end
                end
                EMIT: begin
                    if (iReady_BM_Class) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oReady_AM_Output = w_ready;
    assign oValid_BM_Class  = r_valid;
    assign oData_BM_Class   = r_class;

`ifdef OUTPUT_ARGMAX_SCORE_EN
    logic [WO-1:0] r_score;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_score <= '0;
        end else if (w_cap && (NO == 1)) begin
            r_score <= w_in_elem0;
        end else if (!w_cap && (r_state == SCAN) && w_last) begin
            r_score <= w_gt ? w_elem : r_best;
        end
    end

    assign oData_BM_Score = r_score;
`else
    // Without the score port the winning value lives only in r_best.
`endif

endmodule
`default_nettype wire
